// File: rtl/usb_rx_data_buffer_if.sv
// rtl/usb_rx_data_buffer_if.sv - usb_rx side and committed-read side signals of the rx data buffer
interface usb_rx_data_buffer_if #(
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic [2:0]  rx_packet;
    logic [7:0]  rx_packet_data;
    logic        store_rx_packet_data;
    logic        get_rx_data;
    logic        flush;
    logic [7:0]  rx_data;
    logic        rx_data_ready;
    logic [AW:0] buffer_occupancy;
    logic        rx_packet_done;
    logic        rx_error;

    modport master (
        output rx_packet, rx_packet_data, store_rx_packet_data, get_rx_data, flush,
        input  rx_data, rx_data_ready, buffer_occupancy, rx_packet_done, rx_error
    );

    modport slave (
        input  rx_packet, rx_packet_data, store_rx_packet_data, get_rx_data, flush,
        output rx_data, rx_data_ready, buffer_occupancy, rx_packet_done, rx_error
    );
endinterface

// File: rtl/usb_rx_data_buffer.sv
// rtl/usb_rx_data_buffer.sv - packet-aware rx byte buffer with commit/rollback (option: USB_RX_CRC_STRIP_EN)
module usb_rx_data_buffer #(
    parameter int DEPTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    usb_rx_data_buffer_if.slave  bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    typedef enum logic {
        S_IDLE,
        S_RECV
    } state_t;

    localparam logic [2:0] PKT_ERROR = 3'd4;
    localparam logic [2:0] PKT_DONE  = 3'd5;

    logic [7:0] mem [DEPTH];

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] cptr_q, cptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [2:0]       prev_pkt_q, prev_pkt_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             full;
    logic             wr_en;
    logic             pop;
    logic             done_ev;
    logic             err_ev;
    logic             ovf_n;
    logic [PTR_W-1:0] wptr_n;
    logic [PTR_W-1:0] occ;

    always_comb begin
        full    = (wptr_q - rptr_q) == PTR_W'(DEPTH);
        occ     = cptr_q - rptr_q;
        done_ev = (bus.rx_packet == PKT_DONE)  && (prev_pkt_q != PKT_DONE);
        err_ev  = (bus.rx_packet == PKT_ERROR) && (prev_pkt_q != PKT_ERROR);
        wr_en   = bus.store_rx_packet_data && !full;
        pop     = bus.get_rx_data && (occ != '0);
        // wptr_n / ovf_n already include this cycle's strobe, so a same-cycle
        // byte is part of the commit (or the overflow decision).
        wptr_n  = wr_en ? wptr_q + 1'b1 : wptr_q;
        ovf_n   = ovf_q | (bus.store_rx_packet_data & full);

        state_d    = state_q;
        wptr_d     = wptr_n;
        cptr_d     = cptr_q;
        rptr_d     = pop ? rptr_q + 1'b1 : rptr_q;
        prev_pkt_d = bus.rx_packet;
        ovf_d      = ovf_n;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.store_rx_packet_data) begin
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (err_ev) begin
                    state_d = S_IDLE;
                    wptr_d  = cptr_q;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                end else if (done_ev) begin
                    state_d = S_IDLE;
                    ovf_d   = 1'b0;
`ifdef USB_RX_CRC_STRIP_EN
                    // Trailing CRC16 is dropped from the tentative region as well,
                    // so the next packet does not append behind stale CRC bytes.
                    if (ovf_n || ((wptr_n - cptr_q) < PTR_W'(2))) begin
                        wptr_d = cptr_q;
                        err_d  = 1'b1;
                    end else begin
                        cptr_d = wptr_n - PTR_W'(2);
                        wptr_d = wptr_n - PTR_W'(2);
                        done_d = 1'b1;
                    end
`else
                    if (ovf_n) begin
                        wptr_d = cptr_q;
                        err_d  = 1'b1;
                    end else begin
                        cptr_d = wptr_n;
                        done_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.flush) begin
            state_d    = S_IDLE;
            wptr_d     = '0;
            cptr_d     = '0;
            rptr_d     = '0;
            prev_pkt_d = '0;
            ovf_d      = 1'b0;
            done_d     = 1'b0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wptr_q     <= '0;
            cptr_q     <= '0;
            rptr_q     <= '0;
            prev_pkt_q <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wptr_q     <= wptr_d;
            cptr_q     <= cptr_d;
            rptr_q     <= rptr_d;
            prev_pkt_q <= prev_pkt_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && wr_en) begin
            mem[wptr_q[AW-1:0]] <= bus.rx_packet_data;
        end
    end

    assign bus.rx_data          = mem[rptr_q[AW-1:0]];
    assign bus.rx_data_ready    = (occ != '0);
    assign bus.buffer_occupancy = occ;
    assign bus.rx_packet_done   = done_q;
    assign bus.rx_error         = err_q;

endmodule

// File: tb/tb_usb_rx_data_buffer.sv
// tb/tb_usb_rx_data_buffer.sv - directed bench for usb_rx_data_buffer (DEPTH 64 and DEPTH 4 instances)
module tb_usb_rx_data_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] pkt = 3'd0;
    logic [7:0] dat = 8'd0;
    logic       stb = 1'b0;
    logic       get = 1'b0;
    logic       fl  = 1'b0;
    logic       sel_small = 1'b0;

    int tests = 0;
    int fails = 0;

    usb_rx_data_buffer_if #(.DEPTH(64)) if_big ();
    usb_rx_data_buffer_if #(.DEPTH(4))  if_small ();

    assign if_big.rx_packet              = sel_small ? 3'd0 : pkt;
    assign if_big.rx_packet_data         = sel_small ? 8'd0 : dat;
    assign if_big.store_rx_packet_data   = sel_small ? 1'b0 : stb;
    assign if_big.get_rx_data            = sel_small ? 1'b0 : get;
    assign if_big.flush                  = sel_small ? 1'b0 : fl;
    assign if_small.rx_packet            = sel_small ? pkt : 3'd0;
    assign if_small.rx_packet_data       = sel_small ? dat : 8'd0;
    assign if_small.store_rx_packet_data = sel_small ? stb : 1'b0;
    assign if_small.get_rx_data          = sel_small ? get : 1'b0;
    assign if_small.flush                = sel_small ? fl  : 1'b0;

    usb_rx_data_buffer #(.DEPTH(64)) dut_big   (.clk(clk), .rst(rst), .bus(if_big));
    usb_rx_data_buffer #(.DEPTH(4))  dut_small (.clk(clk), .rst(rst), .bus(if_small));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        stb = 1'b1;
        dat = b;
        tick();
        stb = 1'b0;
    endtask

    task automatic pop1();
        get = 1'b1;
        tick();
        get = 1'b0;
    endtask

    task automatic idle();
        pkt = 3'd0;
        tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", {31'd0, if_big.rx_data_ready}, 32'd0);
        chk("rst_occ",   {25'd0, if_big.buffer_occupancy}, 32'd0);
        chk("rst_done",  {31'd0, if_big.rx_packet_done}, 32'd0);
        chk("rst_err",   {31'd0, if_big.rx_error}, 32'd0);

`ifdef USB_RX_CRC_STRIP_EN
        send(8'h01); send(8'h02); send(8'hFF); send(8'hE8);
        pkt = 3'd5; tick();
        chk("crc_done", {31'd0, if_big.rx_packet_done}, 32'd1);
        chk("crc_occ",  {25'd0, if_big.buffer_occupancy}, 32'd2);
        chk("crc_b0",   {24'd0, if_big.rx_data}, 32'h01);
        idle();
        pop1();
        chk("crc_b1",   {24'd0, if_big.rx_data}, 32'h02);
        pop1();
        chk("crc_empty", {25'd0, if_big.buffer_occupancy}, 32'd0);
        send(8'h55);
        pkt = 3'd5; tick();
        chk("crc_short_err",  {31'd0, if_big.rx_error}, 32'd1);
        chk("crc_short_done", {31'd0, if_big.rx_packet_done}, 32'd0);
        chk("crc_short_occ",  {25'd0, if_big.buffer_occupancy}, 32'd0);
        idle();
`else
        // basic commit
        send(8'hAA); send(8'hAF);
        pkt = 3'd5; tick();
        chk("c_done",  {31'd0, if_big.rx_packet_done}, 32'd1);
        chk("c_err",   {31'd0, if_big.rx_error}, 32'd0);
        chk("c_occ",   {25'd0, if_big.buffer_occupancy}, 32'd2);
        chk("c_ready", {31'd0, if_big.rx_data_ready}, 32'd1);
        chk("c_head",  {24'd0, if_big.rx_data}, 32'hAA);
        tick();
        chk("c_pulse_once", {31'd0, if_big.rx_packet_done}, 32'd0);
        idle();
        pop1();
        chk("c_pop_head", {24'd0, if_big.rx_data}, 32'hAF);
        chk("c_pop_occ",  {25'd0, if_big.buffer_occupancy}, 32'd1);
        pop1();
        chk("c_empty_occ",   {25'd0, if_big.buffer_occupancy}, 32'd0);
        chk("c_empty_ready", {31'd0, if_big.rx_data_ready}, 32'd0);
        pop1();
        chk("c_pop_empty_ignored", {25'd0, if_big.buffer_occupancy}, 32'd0);

        // rollback on ERROR
        send(8'h11);
        pkt = 3'd5; tick(); idle();
        send(8'h22); send(8'h33);
        pkt = 3'd4; tick();
        chk("rb_err",  {31'd0, if_big.rx_error}, 32'd1);
        chk("rb_done", {31'd0, if_big.rx_packet_done}, 32'd0);
        chk("rb_occ",  {25'd0, if_big.buffer_occupancy}, 32'd1);
        chk("rb_head", {24'd0, if_big.rx_data}, 32'h11);
        idle();
        chk("rb_err_clr", {31'd0, if_big.rx_error}, 32'd0);
        pop1();

        // strobe on the DONE edge is committed
        send(8'h01);
        stb = 1'b1; dat = 8'h5A; pkt = 3'd5; tick(); stb = 1'b0;
        chk("sd_occ", {25'd0, if_big.buffer_occupancy}, 32'd2);
        idle();
        pop1();
        chk("sd_head", {24'd0, if_big.rx_data}, 32'h5A);
        pop1();

        // strobe on the ERROR edge is discarded
        send(8'h77);
        stb = 1'b1; dat = 8'h78; pkt = 3'd4; tick(); stb = 1'b0;
        chk("se_err", {31'd0, if_big.rx_error}, 32'd1);
        chk("se_occ", {25'd0, if_big.buffer_occupancy}, 32'd0);
        idle();

        // pop together with a 3-byte commit at occupancy 1
        send(8'hC0);
        pkt = 3'd5; tick(); idle();
        send(8'hC1); send(8'hC2); send(8'hC3);
        pkt = 3'd5; get = 1'b1; tick(); get = 1'b0;
        chk("pc_occ",  {25'd0, if_big.buffer_occupancy}, 32'd3);
        chk("pc_head", {24'd0, if_big.rx_data}, 32'hC1);
        idle();
        pop1(); chk("pc_h2", {24'd0, if_big.rx_data}, 32'hC2);
        pop1(); chk("pc_h3", {24'd0, if_big.rx_data}, 32'hC3);
        pop1(); chk("pc_empty", {25'd0, if_big.buffer_occupancy}, 32'd0);

        // flush mid-packet, with a DONE arriving on the flush edge
        send(8'hD0); send(8'hD1);
        pkt = 3'd5; tick(); idle();
        send(8'hE0); send(8'hE1); send(8'hE2);
        fl = 1'b1; pkt = 3'd5; tick(); fl = 1'b0;
        chk("fl_occ",   {25'd0, if_big.buffer_occupancy}, 32'd0);
        chk("fl_ready", {31'd0, if_big.rx_data_ready}, 32'd0);
        chk("fl_done",  {31'd0, if_big.rx_packet_done}, 32'd0);
        chk("fl_err",   {31'd0, if_big.rx_error}, 32'd0);
        idle();
        send(8'h42);
        pkt = 3'd5; tick();
        chk("fl_next_done", {31'd0, if_big.rx_packet_done}, 32'd1);
        chk("fl_next_head", {24'd0, if_big.rx_data}, 32'h42);
        chk("fl_next_wptr", {25'd0, dut_big.wptr_q}, 32'd1);
        chk("fl_next_rptr", {25'd0, dut_big.rptr_q}, 32'd0);
        idle();
        pop1();

        // reset mid-packet
        send(8'hD0); send(8'hD1);
        pkt = 3'd5; tick(); idle();
        send(8'hE0); send(8'hE1); send(8'hE2);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rs_occ", {25'd0, if_big.buffer_occupancy}, 32'd0);
        chk("rs_err", {31'd0, if_big.rx_error}, 32'd0);
        send(8'h43);
        pkt = 3'd5; tick();
        chk("rs_next_occ",  {25'd0, if_big.buffer_occupancy}, 32'd1);
        chk("rs_next_head", {24'd0, if_big.rx_data}, 32'h43);
        chk("rs_next_wptr", {25'd0, dut_big.wptr_q}, 32'd1);
        idle();

        // overflow on the DEPTH=4 instance
        sel_small = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) send(8'(8'h90 + i));
        pkt = 3'd5; tick();
        chk("ov_err",  {31'd0, if_small.rx_error}, 32'd1);
        chk("ov_done", {31'd0, if_small.rx_packet_done}, 32'd0);
        chk("ov_occ",  {29'd0, if_small.buffer_occupancy}, 32'd0);
        idle();
        send(8'h99);
        pkt = 3'd5; tick();
        chk("ov_next_done", {31'd0, if_small.rx_packet_done}, 32'd1);
        chk("ov_next_occ",  {29'd0, if_small.buffer_occupancy}, 32'd1);
        chk("ov_next_head", {24'd0, if_small.rx_data}, 32'h99);
        idle();
        pop1();
        for (int i = 0; i < 4; i++) send(8'(8'hA0 + i));
        pkt = 3'd5; tick();
        chk("ov_full_done", {31'd0, if_small.rx_packet_done}, 32'd1);
        chk("ov_full_occ",  {29'd0, if_small.buffer_occupancy}, 32'd4);
        chk("ov_full_head", {24'd0, if_small.rx_data}, 32'hA0);
        idle();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
